// File: rtl/hs_rr_arbiter_pkg.sv
// Shared definitions for the round-robin handshake arbiter.
//   DW_DEF     : default data width of every source and the destination
//   NS_DEF     : default number of requesting sources
//   clog2_min1 : ceil(log2(n)), never less than 1, used for index widths
package hs_rr_arbiter_pkg;

  localparam int DW_DEF = 8;
  localparam int NS_DEF = 4;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/hs_rr_arbiter_rr_pick.sv
// Combinational round-robin selector.
//   req : request vector, bit i belongs to source i
//   ptr : index where the search starts (highest priority this cycle)
//   win : first asserted request at or after ptr, searching upward modulo NS
//   any : at least one request is asserted
module rr_pick
  import hs_rr_arbiter_pkg::*;
#(
  parameter int NS = NS_DEF,
  parameter int PW = clog2_min1(NS)
) (
  input  logic [NS-1:0] req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] win,
  output logic          any
);

  int idx;

  // Scan offsets from farthest to nearest so the nearest asserted
  // request from ptr is the last one written and therefore wins.
  always_comb begin
    win = '0;
    any = |req;
    idx = 0;
    for (int i = NS - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NS) idx = idx - NS;
      if (req[idx]) win = PW'(idx);
    end
  end

endmodule

// File: rtl/hs_rr_arbiter.sv
// Round-robin arbiter merging NS valid/ready sources into one registered
// destination stream.
//   clk, rst : single clock, synchronous active-high reset
//   s_valid  : per-source valid
//   s_ready  : per-source ready, one-hot or zero
//   s_data   : packed source data, source i at [i*DW +: DW]
//   m_valid  : destination valid
//   m_ready  : destination ready
//   m_data   : destination data
//   m_src    : index of the source that supplied m_data
// xfer_cnt counts destination transfers and is visible hierarchically.
module hs_rr_arbiter
  import hs_rr_arbiter_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int NS = NS_DEF,
  localparam int PW = clog2_min1(NS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NS-1:0]    s_valid,
  output logic [NS-1:0]    s_ready,
  input  logic [NS*DW-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DW-1:0]    m_data,
  output logic [PW-1:0]    m_src
);

  logic          vld_p0;
  logic [DW-1:0] data_p0;
  logic [PW-1:0] src_p0;
  logic [PW-1:0] ptr;
  logic [31:0]   xfer_cnt;

  logic [PW-1:0] win;
  logic          any;
  logic          open;
  logic          acc;

  rr_pick #(
    .NS (NS),
    .PW (PW)
  ) u_pick (
    .req (s_valid),
    .ptr (ptr),
    .win (win),
    .any (any)
  );

  // The stage can take a new word when it is empty or being drained now;
  // reset blocks acceptance so a word offered during reset is not lost.
  assign open = !vld_p0 || m_ready;
  assign acc  = open && any && !rst;

  always_comb begin
    s_ready = '0;
    if (acc) s_ready[win] = 1'b1;
  end

  // ---- stage p0: output register, arbitration pointer, transfer count ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0   <= 1'b0;
      data_p0  <= '0;
      src_p0   <= '0;
      ptr      <= '0;
      xfer_cnt <= '0;
    end else begin
      if (vld_p0 && m_ready) xfer_cnt <= xfer_cnt + 32'd1;
      if (acc) begin
        vld_p0  <= 1'b1;
        data_p0 <= s_data[int'(win)*DW +: DW];
        src_p0  <= win;
        ptr     <= (win == PW'(NS - 1)) ? '0 : win + 1'b1;
      end else if (m_ready) begin
        vld_p0 <= 1'b0;
      end
    end
  end

  assign m_valid = vld_p0;
  assign m_data  = data_p0;
  assign m_src   = src_p0;

endmodule

// File: doc/hs_rr_arbiter.md
HS_RR_ARBITER -- requirements
Module: hs_rr_arbiter

Interface
REQ-001 Parameter DW, default 8: data width of every source and of the destination.
REQ-002 Parameter NS, default 4: number of requesting sources (2..8).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 s_valid  input  NS  per-source valid; bit i belongs to source i.
REQ-006 s_ready  output  NS  per-source ready; at most one bit high per cycle.
REQ-007 s_data  input  NS*DW  packed source data; source i occupies bits [i*DW +: DW].
REQ-008 m_valid  output  1  destination-side valid.
REQ-009 m_ready  input  1  destination-side ready.
REQ-010 m_data  output  DW  destination-side data.
REQ-011 m_src  output  clog2(NS) (min 1)  index of the source that supplied m_data.

Function
REQ-012 A transfer on either side SHALL occur only in a cycle where valid and ready are both high at the rising edge.
REQ-013 Output stage SHALL be a single register holding m_valid, m_data and m_src.
REQ-014 Output stage "open" SHALL mean m_valid=0 or m_ready=1.
REQ-015 s_ready[i] SHALL be 1 only when the stage is open and source i is the current round-robin winner among asserted s_valid bits.
REQ-016 s_ready SHALL be all-zero when the stage is not open or no s_valid bit is set.
REQ-017 Winner SHALL be the first asserted s_valid at or after index ptr, searching upward modulo NS.
REQ-018 On an accepted source transfer from source k, the block SHALL load m_data=s_data[k], m_src=k, m_valid=1 and set ptr=(k+1) mod NS.
REQ-019 Source-to-destination latency SHALL be exactly 1 cycle: data accepted at edge n is presented on m_data after edge n.
REQ-020 When open with no source accepted, m_valid SHALL be cleared if m_ready=1; ptr SHALL be unchanged.
REQ-021 While m_valid=1 and m_ready=0, m_valid, m_data and m_src SHALL remain stable and no source transfer SHALL occur.
REQ-022 Simultaneous m_ready=1 and a source acceptance in the same cycle SHALL give full throughput: one word per cycle with no bubble.
REQ-023 With a single persistent requester, that requester SHALL be granted every open cycle.
REQ-024 With all NS requesters persistent, grants SHALL rotate 0,1,...,NS-1,0 and no source SHALL wait more than NS-1 transfers.
REQ-025 A source dropping s_valid before acceptance SHALL be skipped without altering ptr.
REQ-026 A 32-bit transfer counter xfer_cnt (internal, observable to the bench) SHALL increment on each m_valid&&m_ready and wrap from 2^32-1 to 0.

Reset
REQ-027 While rst=1 at a rising edge: m_valid=0, m_data=0, m_src=0, ptr=0, xfer_cnt=0.
REQ-028 While rst=1, s_ready SHALL be all-zero.
REQ-029 Reset asserted mid-transfer SHALL discard the held word, and no s_ready SHALL assert in that cycle.
REQ-030 The first grant after reset release SHALL search from index 0.

Structure
REQ-031 A shared package/header SHALL hold the DW and NS defaults and the clog2 helper, and SHALL be reused by source and destination blocks.
REQ-032 Round-robin selection SHALL be one combinational sub-module, rr_pick (inputs req, ptr; outputs winner index and any-valid flag).
REQ-033 All state (output register, ptr, xfer_cnt) SHALL reside in hs_rr_arbiter.

Verification
REQ-034 Reset check: rst=1 for 3 cycles with all s_valid=1 -> m_valid=0 and s_ready=0000 throughout; first grant after release goes to source 0.
REQ-035 Round-robin check: NS=4, all s_valid=1, m_ready=1, s_data[i]=8'h10+i -> m_data sequence 10,11,12,13,10 on consecutive cycles with m_src 0,1,2,3,0.
REQ-036 Backpressure check: m_ready=0 for cycles 5-9 while m_valid=1 with m_data=8'h12 -> m_data, m_src and m_valid hold, s_ready=0000; transfer resumes on the cycle m_ready returns.
REQ-037 Skip check: only s_valid[2] and s_valid[0] set, ptr=1 -> source 2 granted first, then source 0; ptr ends at 1.
REQ-038 Mid-run reset check: assert rst while m_valid=1, m_ready=0 -> next cycle m_valid=0, xfer_cnt=0, no source transfer lost or duplicated, verified by a per-source transfer scoreboard.
REQ-039 Throughput check: single requester source 3 streaming 100 words with m_ready=1 -> 100 transfers in 101 cycles and xfer_cnt=100.
